// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg : shared encodings for the multicycle controller
//          (state enum, opcodes, functs, aluop and ALU control codes).
// Optional: MC_CONTROL_BNE_EN adds the BNEEX state.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`ifdef MC_CONTROL_BNE_EN
    JEX     = 4'd11,
    BNEEX   = 4'd12
`else
    JEX     = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/mc_control_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder : combinational aluop/funct to 3-bit ALU control decode.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FUNCT_ADD: o_alucontrol = ALU_ADD;
          FUNCT_SUB: o_alucontrol = ALU_SUB;
          FUNCT_AND: o_alucontrol = ALU_AND;
          FUNCT_OR:  o_alucontrol = ALU_OR;
          FUNCT_SLT: o_alucontrol = ALU_SLT;
          default:   o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control : Moore-decoded multicycle MIPS controller FSM.
// Optional: MC_CONTROL_BNE_EN adds bne support (state BNEEX).
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic [1:0] w_aluop;
`ifdef MC_CONTROL_BNE_EN
  logic       w_branchne;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JEX;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:       w_next = BNEEX;
`endif
          default:      w_next = FETCH;
        endcase
      end
      MEMADR:  w_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   w_next = MEMWB;
      RTYPEEX: w_next = RTYPEWB;
      ADDIEX:  w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_aluop    = ALUOP_ADD;
    iord       = 1'b0;
    alusrca    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
`ifdef MC_CONTROL_BNE_EN
    w_branchne = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb   = 2'b01;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
`ifdef MC_CONTROL_BNE_EN
      BNEEX: begin
        alusrca    = 1'b1;
        w_aluop    = ALUOP_SUB;
        pcsrc      = 2'b01;
        w_branchne = 1'b1;
      end
`endif
      ADDIWB: w_regwrite = 1'b1;
      JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates the architectural write enables within the same cycle.
`ifdef MC_CONTROL_BNE_EN
  assign pcen = ~reset & (w_pcwrite | (w_branch & zero) | (w_branchne & ~zero));
`else
  assign pcen = ~reset & (w_pcwrite | (w_branch & zero));
`endif
  assign irwrite  = ~reset & w_irwrite;
  assign memwrite = ~reset & w_memwrite;
  assign regwrite = ~reset & w_regwrite;

  alu_decoder u_alu_decoder (
    .i_aluop      (w_aluop),
    .i_funct      (funct),
    .o_alucontrol (alucontrol)
  );

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control : directed self-checking bench for mc_control.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, irwrite, memwrite, regwrite;
  logic       iord, alusrca, regdst, memtoreg;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [14:0] w_obs;

  int n_pass  = 0;
  int n_total = 0;

  // {pcen,irwrite,memwrite,regwrite, iord,alusrca,regdst,memtoreg, alusrcb, pcsrc, alucontrol}
  localparam logic [14:0] V_FETCH   = 15'b1100_0000_01_00_010;
  localparam logic [14:0] V_DECODE  = 15'b0000_0000_11_00_010;
  localparam logic [14:0] V_MEMADR  = 15'b0000_0100_10_00_010;
  localparam logic [14:0] V_MEMRD   = 15'b0000_1000_00_00_010;
  localparam logic [14:0] V_MEMWB   = 15'b0001_0001_00_00_010;
  localparam logic [14:0] V_MEMWR   = 15'b0010_1000_00_00_010;
  localparam logic [14:0] V_RTWB    = 15'b0001_0010_00_00_010;
  localparam logic [14:0] V_ADDIWB  = 15'b0001_0000_00_00_010;
  localparam logic [14:0] V_JEX     = 15'b1000_0000_00_10_010;
  localparam logic [14:0] V_BR_TAKE = 15'b1000_0100_00_01_110;
  localparam logic [14:0] V_BR_NOT  = 15'b0000_0100_00_01_110;

  assign w_obs = {pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst,
                  memtoreg, alusrcb, pcsrc, alucontrol};

  always #5 clk = ~clk;

  mc_control dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .alusrca    (alusrca),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] exp [3];
    reset = 1'b1; op = 6'b111111; funct = 6'b0; zero = 1'b0;
    step();
    n_total++;
    if ({pcen, irwrite, memwrite, regwrite} !== 4'b0000)
      $display("FAIL reset_we_gated: got %b expected 0000", {pcen, irwrite, memwrite, regwrite});
    else n_pass++;
    step();
    n_total++;
    if (w_obs !== 15'b0000_0000_01_00_010)
      $display("FAIL reset_held_fetch: got %b expected %b", w_obs, 15'b0000_0000_01_00_010);
    else n_pass++;
    reset = 1'b0;
    exp[0] = V_FETCH; exp[1] = V_DECODE; exp[2] = V_FETCH;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(); else #1;
      n_total++;
      if (w_obs !== exp[i]) $display("FAIL reset_release[%0d]: got %b expected %b", i, w_obs, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_lw();
    logic [14:0] exp [6];
    op = 6'b100011; funct = 6'b0; zero = 1'b0;
    exp[0] = V_FETCH; exp[1] = V_DECODE; exp[2] = V_MEMADR;
    exp[3] = V_MEMRD; exp[4] = V_MEMWB;  exp[5] = V_FETCH;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(); else #1;
      n_total++;
      if (w_obs !== exp[i]) $display("FAIL lw[%0d]: got %b expected %b", i, w_obs, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sw();
    logic [14:0] exp [5];
    op = 6'b101011; zero = 1'b0;
    exp[0] = V_FETCH; exp[1] = V_DECODE; exp[2] = V_MEMADR;
    exp[3] = V_MEMWR; exp[4] = V_FETCH;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(); else #1;
      n_total++;
      if (w_obs !== exp[i]) $display("FAIL sw[%0d]: got %b expected %b", i, w_obs, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [6];
    logic [2:0] alu [6];
    logic [14:0] exp [5];
    fn[0] = 6'b101010; alu[0] = 3'b111;
    fn[1] = 6'b100000; alu[1] = 3'b010;
    fn[2] = 6'b100010; alu[2] = 3'b110;
    fn[3] = 6'b100100; alu[3] = 3'b000;
    fn[4] = 6'b100101; alu[4] = 3'b001;
    fn[5] = 6'b000111; alu[5] = 3'b010;
    for (int k = 0; k < 6; k++) begin
      op = 6'b000000; funct = fn[k]; zero = 1'b0;
      exp[0] = V_FETCH; exp[1] = V_DECODE; exp[2] = {12'b0000_0100_00_00, alu[k]};
      exp[3] = V_RTWB;  exp[4] = V_FETCH;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) step(); else #1;
        n_total++;
        if (w_obs !== exp[i])
          $display("FAIL rtype_f%b[%0d]: got %b expected %b", fn[k], i, w_obs, exp[i]);
        else n_pass++;
      end
    end
    funct = 6'b0;
  endtask

  task automatic test_addi();
    logic [14:0] exp [5];
    op = 6'b001000; zero = 1'b0;
    exp[0] = V_FETCH;  exp[1] = V_DECODE; exp[2] = V_MEMADR;
    exp[3] = V_ADDIWB; exp[4] = V_FETCH;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(); else #1;
      n_total++;
      if (w_obs !== exp[i]) $display("FAIL addi[%0d]: got %b expected %b", i, w_obs, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops [3];
    logic        zs  [3];
    logic [14:0] mid [3];
    logic [14:0] exp [4];
    ops[0] = 6'b000100; zs[0] = 1'b1; mid[0] = V_BR_TAKE;
    ops[1] = 6'b000100; zs[1] = 1'b0; mid[1] = V_BR_NOT;
    ops[2] = 6'b000010; zs[2] = 1'b0; mid[2] = V_JEX;
    for (int k = 0; k < 3; k++) begin
      op = ops[k]; zero = zs[k];
      exp[0] = V_FETCH; exp[1] = V_DECODE; exp[2] = mid[k]; exp[3] = V_FETCH;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) step(); else #1;
        n_total++;
        if (w_obs !== exp[i])
          $display("FAIL br_op%b_z%b[%0d]: got %b expected %b", ops[k], zs[k], i, w_obs, exp[i]);
        else n_pass++;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_unknown();
    logic [14:0] exp [3];
    op = 6'b111111; zero = 1'b1;
    exp[0] = V_FETCH; exp[1] = V_DECODE; exp[2] = V_FETCH;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(); else #1;
      n_total++;
      if (w_obs !== exp[i]) $display("FAIL unknown[%0d]: got %b expected %b", i, w_obs, exp[i]);
      else n_pass++;
    end
    zero = 1'b0;
  endtask

  task automatic test_reset_mid();
    op = 6'b101011; zero = 1'b0;
    step(); step(); step();
    n_total++;
    if (w_obs !== V_MEMWR) $display("FAIL rstmid_memwr: got %b expected %b", w_obs, V_MEMWR);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (w_obs !== 15'b0000_1000_00_00_010)
      $display("FAIL rstmid_gated: got %b expected %b", w_obs, 15'b0000_1000_00_00_010);
    else n_pass++;
    step();
    reset = 1'b0;
    #1;
    n_total++;
    if (w_obs !== V_FETCH) $display("FAIL rstmid_fetch: got %b expected %b", w_obs, V_FETCH);
    else n_pass++;
  endtask

  task automatic test_bne();
    logic [14:0] exp [4];
    logic        zs  [2];
    zs[0] = 1'b0; zs[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      op = 6'b000101; zero = zs[k];
      exp[0] = V_FETCH; exp[1] = V_DECODE;
`ifdef MC_CONTROL_BNE_EN
      exp[2] = zs[k] ? V_BR_NOT : V_BR_TAKE; exp[3] = V_FETCH;
      for (int i = 0; i < 4; i++) begin
`else
      exp[2] = V_FETCH; exp[3] = V_FETCH;
      for (int i = 0; i < 3; i++) begin
`endif
        if (i > 0) step(); else #1;
        n_total++;
        if (w_obs !== exp[i])
          $display("FAIL bne_z%b[%0d]: got %b expected %b", zs[k], i, w_obs, exp[i]);
        else n_pass++;
      end
    end
    zero = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_addi();
    test_branch_jump();
    test_unknown();
    test_reset_mid();
    test_bne();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
